// File: rtl/line_window_reader.sv
// 3x3 raster window generator with two internal row-length line delays.
// Define WINDOW_STRIDE2_EN to emit only windows whose (row, col) are both even.
module line_window_reader #(
  parameter int WIDTH = 16,
  parameter int COLS  = 224,
  parameter int ROWS  = 224
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ivalid,
  input  logic [WIDTH-1:0]          idata,
  output logic                      ovalid,
  output logic [9*WIDTH-1:0]        owindow,
  output logic [$clog2(ROWS)-1:0]   orow,
  output logic [$clog2(COLS)-1:0]   ocol,
  output logic                      oframe_end
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [CW-1:0] CMAX = CW'(COLS - 1);
  localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);

`ifdef WINDOW_STRIDE2_EN
  localparam logic [CW-1:0] CLAST = CW'((COLS - 1) & ~1);
  localparam logic [RW-1:0] RLAST = RW'((ROWS - 1) & ~1);
`else
  localparam logic [CW-1:0] CLAST = CMAX;
  localparam logic [RW-1:0] RLAST = RMAX;
`endif

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [WIDTH-1:0] l0 [COLS];
  logic [WIDTH-1:0] l1 [COLS];
  logic [WIDTH-1:0] up1;
  logic [WIDTH-1:0] up2;
  logic             hit;
  logic             fend;

  assign up1 = l0[col];
  assign up2 = l1[col];

  always_comb begin
    hit  = (row >= RW'(2)) && (col >= CW'(2));
`ifdef WINDOW_STRIDE2_EN
    hit  = hit && !row[0] && !col[0];
`endif
    fend = hit && (row == RLAST) && (col == CLAST);
  end

  // Line memories: no reset, stale contents are masked by the row gating.
  always_ff @(posedge clock) begin
    if (ivalid) begin
      l1[col] <= up1;
      l0[col] <= idata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (ivalid) begin
      if (col == CMAX) begin
        col <= '0;
        row <= (row == RMAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window shifts left; new right column is {row r-2, row r-1, row r}.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovalid     <= 1'b0;
      owindow    <= '0;
      orow       <= '0;
      ocol       <= '0;
      oframe_end <= 1'b0;
    end else if (ivalid) begin
      for (int i = 0; i < 3; i++) begin
        owindow[(3*i)*WIDTH +: WIDTH]   <= owindow[(3*i+1)*WIDTH +: WIDTH];
        owindow[(3*i+1)*WIDTH +: WIDTH] <= owindow[(3*i+2)*WIDTH +: WIDTH];
      end
      owindow[2*WIDTH +: WIDTH] <= up2;
      owindow[5*WIDTH +: WIDTH] <= up1;
      owindow[8*WIDTH +: WIDTH] <= idata;
      ovalid     <= hit;
      orow       <= row;
      ocol       <= col;
      oframe_end <= fend;
    end else begin
      ovalid     <= 1'b0;
      oframe_end <= 1'b0;
    end
  end

endmodule
